// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: slot record, select-width
// computation and the per-source youngest-producer search.
package hazard_pkg;

  // Storage is sized for the widest legal configuration; narrower register
  // addresses are zero-extended into the record.
  localparam int MaxRegAw = 8;
  localparam int MaxDepth = 8;

  localparam logic [MaxRegAw-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic                valid;
    logic [MaxRegAw-1:0] rd;
    logic [MaxRegAw-1:0] rs1;
    logic [MaxRegAw-1:0] rs2;
    logic                rs1_used;
    logic                rs2_used;
    logic                regwrite;
    logic                is_load;
  } slot_t;

  // Index 1 is EX; entries above the configured depth stay invalid.
  typedef slot_t [MaxDepth:1] slot_vec_t;

  function automatic int unsigned sel_width(int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic writes(slot_t s, logic [MaxRegAw-1:0] r);
    return s.valid && s.regwrite && (s.rd == r) && (r != REG_ZERO);
  endfunction

  // Smallest slot index in [lo, hi] that writes r, or 0 when none does.
  function automatic int youngest_writer(slot_vec_t slots, int lo, int hi,
                                         logic [MaxRegAw-1:0] r);
    int idx;
    idx = 0;
    for (int k = MaxDepth; k >= 1; k--) begin
      if (k >= lo && k <= hi && writes(slots[k], r)) idx = k;
    end
    return idx;
  endfunction

  // The youngest producer decides: a younger non-load shadows an older load.
  function automatic logic load_use_hit(slot_vec_t slots, logic used,
                                        logic [MaxRegAw-1:0] r, int depth,
                                        int load_ready);
    int j;
    j = youngest_writer(slots, 1, depth, r);
    return used && (j != 0) && slots[j].is_load && (j + 1 < load_ready);
  endfunction

  // Forwarding source for an EX operand; a not-yet-ready load is never chosen.
  function automatic int fwd_select(slot_vec_t slots, logic used,
                                    logic [MaxRegAw-1:0] r, int depth,
                                    int load_ready);
    int k;
    k = youngest_writer(slots, 2, depth, r);
    if (!used || k == 0) return 0;
    if (slots[k].is_load && k < load_ready) return 0;
    return k;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // Increment unless already at all-ones.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != '1)) count_d = count_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) count_q <= '0;
    else         count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard control for the in-order pipeline: tracks in-flight destinations,
// raises load-use stalls, issues branch flushes and selects EX forwarding.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned LOAD_READY   = 3,
  parameter int unsigned BRANCH_STAGE = 2,
  parameter int unsigned CNT_W        = 32,
  parameter int unsigned SEL_W        = sel_width(DEPTH)
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    hold_i,
  input  logic                    id_valid_i,
  input  logic [REG_AW-1:0]       id_rs1_i,
  input  logic [REG_AW-1:0]       id_rs2_i,
  input  logic                    id_rs1_used_i,
  input  logic                    id_rs2_used_i,
  input  logic [REG_AW-1:0]       id_rd_i,
  input  logic                    id_regwrite_i,
  input  logic                    id_is_load_i,
  input  logic                    branch_taken_i,
  output logic                    stall_o,
  output logic                    flush_id_o,
  output logic [BRANCH_STAGE-1:0] flush_mask_o,
  output logic [SEL_W-1:0]        ex_fwd_rs1_sel_o,
  output logic [SEL_W-1:0]        ex_fwd_rs2_sel_o,
  output logic [CNT_W-1:0]        stall_count_o,
  output logic [CNT_W-1:0]        flush_count_o
);

  slot_vec_t slots_q, slots_d;
  slot_t     id_rec;
  logic      stall_raw;

  // Pack the ID-stage instruction into a slot record.
  always_comb begin
    id_rec          = '0;
    id_rec.valid    = 1'b1;
    id_rec.rd       = MaxRegAw'(id_rd_i);
    id_rec.rs1      = MaxRegAw'(id_rs1_i);
    id_rec.rs2      = MaxRegAw'(id_rs2_i);
    id_rec.rs1_used = id_rs1_used_i;
    id_rec.rs2_used = id_rs2_used_i;
    id_rec.regwrite = id_regwrite_i;
    id_rec.is_load  = id_is_load_i;
  end

  assign stall_raw = id_valid_i &
      (load_use_hit(slots_q, id_rs1_used_i, MaxRegAw'(id_rs1_i), int'(DEPTH), int'(LOAD_READY)) |
       load_use_hit(slots_q, id_rs2_used_i, MaxRegAw'(id_rs2_i), int'(DEPTH), int'(LOAD_READY)));

  // A taken branch wins over a load-use stall; hold masks both.
  assign stall_o      = stall_raw & ~branch_taken_i & ~hold_i;
  assign flush_id_o   = branch_taken_i & ~hold_i;
  assign flush_mask_o = {BRANCH_STAGE{flush_id_o}};

  // Forwarding selects for the instruction in EX (slot 1).
  always_comb begin
    ex_fwd_rs1_sel_o = '0;
    ex_fwd_rs2_sel_o = '0;
    if (slots_q[1].valid) begin
      ex_fwd_rs1_sel_o = SEL_W'(fwd_select(slots_q, slots_q[1].rs1_used, slots_q[1].rs1,
                                           int'(DEPTH), int'(LOAD_READY)));
      ex_fwd_rs2_sel_o = SEL_W'(fwd_select(slots_q, slots_q[1].rs2_used, slots_q[1].rs2,
                                           int'(DEPTH), int'(LOAD_READY)));
    end
  end

  // Shift the pipeline, insert ID or a bubble, then kill the wrong-path slots.
  always_comb begin
    slots_d = slots_q;
    if (!hold_i) begin
      for (int k = int'(DEPTH); k >= 2; k--) slots_d[k] = slots_q[k-1];
      slots_d[1] = (id_valid_i && !stall_raw && !branch_taken_i) ? id_rec : '0;
      // Post-shift slots 1..BRANCH_STAGE hold what was younger than the branch.
      if (branch_taken_i) begin
        for (int k = 1; k <= int'(BRANCH_STAGE); k++) slots_d[k].valid = 1'b0;
      end
    end
  end

  // Slot state register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) slots_q <= '0;
    else         slots_q <= slots_d;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .inc_i   (stall_o),
    .count_o (stall_count_o)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .inc_i   (flush_id_o),
    .count_o (flush_count_o)
  );

endmodule
